// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB camera configuration sequencer.
package sccb_cfg_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PWRUP,
      FETCH,
      DECODE,
      LAUNCH,
      XFER,
      STOP_REQ,
      WAIT_IDLE,
      DELAY,
      DONE,
      ERROR
   } state_t;

   localparam logic [15:0] END_MARK    = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK  = 16'hFFF0;
   localparam logic [6:0]  OV7670_ADDR = 7'h21;

endpackage

// File: rtl/sccb_cfg_seq_if.sv
// Handshake between the configuration sequencer and the byte-level I2C master.
interface sccb_cfg_seq_if;

   logic       I2C_En;
   logic [6:0] addr;
   logic       CR_RW;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       tx_ready;
   logic       I2C_start;
   logic       I2C_stop;
   logic [1:0] length;

   modport master (
      output I2C_En, addr, CR_RW, tx_data, I2C_start, I2C_stop, length,
      input  tx_done, tx_ready
   );

   modport slave (
      input  I2C_En, addr, CR_RW, tx_data, I2C_start, I2C_stop, length,
      output tx_done, tx_ready
   );

endinterface

// File: rtl/cfg_wait_timer.sv
// Up-counter shared by the power-up wait, delay markers and the transfer watchdog.
module cfg_wait_timer #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         count_en,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   // expired marks the last cycle of a limit-cycle window started by load
   assign expired = (count == limit - W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks a {reg,val} ROM and writes each entry to the camera over SCCB,
// with delay markers, per-entry retries on NACK and a transfer watchdog.
module sccb_cfg_seq
   import sccb_cfg_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = OV7670_ADDR,
   parameter int         PWRUP_CYC   = 1_000_000,
   parameter int         DELAY_CYC   = 1_000_000,
   parameter int         TIMEOUT_CYC = 200_000,
   parameter int         MAX_RETRY   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [7:0]            rom_addr,
   input  logic [15:0]           rom_data,
   sccb_cfg_seq_if.master        bus
);

   localparam int MAX_A   = (PWRUP_CYC > DELAY_CYC) ? PWRUP_CYC : DELAY_CYC;
   localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   state_t               state_q, state_d;
   logic [7:0]           rom_addr_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [1:0]           done_cnt_q, done_cnt_d;
   logic [7:0]           reg_q, val_q;
   logic                 tmr_load, tmr_en, tmr_expired;
   logic [TMR_W-1:0]     tmr_limit;

   cfg_wait_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .count_en (tmr_en),
      .limit    (tmr_limit),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rom_addr   <= '0;
         retry_q    <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr   <= rom_addr_d;
         retry_q    <= retry_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Entry payload is data only; it is always rewritten in DECODE before use.
   always_ff @(posedge clk) begin
      if (state_q == DECODE) begin
         reg_q <= rom_data[15:8];
         val_q <= rom_data[7:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr;
      retry_d    = retry_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d    = PWRUP;
               rom_addr_d = '0;
               retry_d    = '0;
            end
         end
         PWRUP:  if (tmr_expired) state_d = FETCH;
         FETCH:  state_d = DECODE;
         DECODE: begin
            if (rom_data == END_MARK)        state_d = DONE;
            else if (rom_data == DELAY_MARK) state_d = DELAY;
            else                             state_d = LAUNCH;
         end
         DELAY: begin
            if (tmr_expired) begin
               if (rom_addr == 8'hFF) begin
                  state_d = ERROR;
               end else begin
                  rom_addr_d = rom_addr + 8'd1;
                  state_d    = FETCH;
               end
            end
         end
         LAUNCH: begin
            done_cnt_d = '0;
            if (bus.tx_ready) state_d = XFER;
         end
         XFER: begin
            // A byte ACK outranks a simultaneous master self-stop.
            if (bus.tx_done) begin
               done_cnt_d = done_cnt_q + 2'd1;
               if (done_cnt_q == 2'd2) state_d = STOP_REQ;
            end else if (bus.tx_ready && done_cnt_q < 2'd3) begin
               retry_d = retry_q + RETRY_W'(1);
               state_d = (int'(retry_q) + 1 < MAX_RETRY) ? LAUNCH : ERROR;
            end else if (tmr_expired) begin
               state_d = ERROR;
            end
         end
         STOP_REQ: if (!bus.tx_ready) state_d = WAIT_IDLE;
         WAIT_IDLE: begin
            if (bus.tx_ready) begin
               if (rom_addr == 8'hFF) begin
                  state_d = ERROR;
               end else begin
                  rom_addr_d = rom_addr + 8'd1;
                  retry_d    = '0;
                  state_d    = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
      done          = (state_q == DONE);
      error         = (state_q == ERROR);
      bus.I2C_En    = (state_q == LAUNCH) && bus.tx_ready;
      bus.I2C_stop  = (state_q == STOP_REQ);
      bus.I2C_start = 1'b0;
      bus.addr      = SLAVE_ADDR;
      bus.CR_RW     = 1'b0;
      bus.length    = 2'd2;
      // tx_data is the byte the master loads at the current ACK phase
      if (done_cnt_q == 2'd0 || (done_cnt_q == 2'd1 && !bus.tx_done)) bus.tx_data = reg_q;
      else                                                             bus.tx_data = val_q;
      tmr_load  = !(state_q == PWRUP || state_q == DELAY || state_q == XFER);
      tmr_en    = !tmr_load;
      case (state_q)
         PWRUP:   tmr_limit = TMR_W'(PWRUP_CYC);
         DELAY:   tmr_limit = TMR_W'(DELAY_CYC);
         default: tmr_limit = TMR_W'(TIMEOUT_CYC);
      endcase
   end

endmodule

// File: doc/sccb_cfg_seq.md
SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  SLAVE_ADDR  7'h21  7-bit camera address.
  PWRUP_CYC  1_000_000  wait after start before first fetch.
  DELAY_CYC  1_000_000  wait for a delay marker.
  TIMEOUT_CYC  200_000  per-transfer watchdog.
  MAX_RETRY  3  attempts per entry.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock.
  reset  in  1  synchronous, active-high reset.
  start  in  1  pulse; begins the configuration run.
  busy  out  1  run in progress.
  done  out  1  level; run finished OK.
  error  out  1  level; run aborted.
  rom_addr  out  8  table index.
  rom_data  in  16  {reg[15:8], val[7:0]}; 1-cycle synchronous read.
  I2C_En  out  1  launch strobe to the I2C master.
  addr  out  7  slave address.
  CR_RW  out  1  read/write select.
  tx_data  out  8  byte to the master.
  tx_done  in  1  per-byte ACK-phase pulse.
  tx_ready  in  1  master idle.
  I2C_start  out  1  restart request.
  I2C_stop  out  1  stop request.
  length  out  2  number of data bytes after the address byte.
REQ-003 Clock is clk; reset is synchronous and active-high on reset; polarity and synchronicity are fixed.

Function
REQ-004 addr=SLAVE_ADDR, CR_RW=0, length=2, I2C_start=0 constantly.
REQ-005 States: IDLE, PWRUP, FETCH, DECODE, LAUNCH, XFER, STOP_REQ, WAIT_IDLE, DELAY, DONE, ERROR.
REQ-006 IDLE/DONE/ERROR + start=1 -> PWRUP; rom_addr=0, retry=0, done=0, error=0.
REQ-007 PWRUP counts PWRUP_CYC cycles -> FETCH.
REQ-008 FETCH holds 1 cycle (ROM latency) -> DECODE; DECODE latches rom_data into reg/val.
REQ-009 DECODE: 16'hFFFF -> DONE; 16'hFFF0 -> DELAY; otherwise -> LAUNCH.
REQ-010 DELAY counts DELAY_CYC cycles, increments rom_addr -> FETCH.
REQ-011 LAUNCH waits for tx_ready=1, then asserts I2C_En for exactly 1 cycle, clears done_cnt and the watchdog -> XFER.
REQ-012 XFER increments done_cnt (2 bits) on each tx_done pulse.
REQ-013 tx_data = reg when done_cnt==0 or (done_cnt==1 and tx_done==0); otherwise val. This is combinational from done_cnt/tx_done.
REQ-014 XFER, third tx_done -> STOP_REQ.
REQ-015 STOP_REQ asserts I2C_stop until tx_ready=0 is seen -> WAIT_IDLE.
REQ-016 WAIT_IDLE waits for tx_ready=1, then rom_addr+1 and retry=0 -> FETCH.
REQ-017 NACK is tx_ready=1 in XFER with done_cnt<3 (the master stopped itself).
REQ-018 On NACK: retry+1; if the new retry<MAX_RETRY -> LAUNCH with the same entry, else -> ERROR.
REQ-019 If the XFER watchdog reaches TIMEOUT_CYC -> ERROR (no retry).
REQ-020 If a NACK and the third tx_done occur in the same cycle, the tx_done wins -> STOP_REQ.
REQ-021 rom_addr 8'hFF + increment without a terminator -> ERROR (no wrap).
REQ-022 busy=1 in every state except IDLE, DONE and ERROR.
REQ-023 done=1 only in DONE; error=1 only in ERROR.
REQ-024 start is ignored while busy.
REQ-025 In the DONE state I2C_En=0 and I2C_stop=0.

Reset
REQ-026 On reset: state=IDLE; rom_addr=0; I2C_En=0; I2C_stop=0; busy=0; done=0; error=0; counters=0.
REQ-027 Reset mid-transfer returns to IDLE immediately, with no stop issued. The bus is recovered by the master's own reset, which the team ties to the same reset.

Structure
REQ-028 Shared package sccb_cfg_pkg holds:
  - the state enum;
  - the END_MARK=16'hFFFF and DELAY_MARK=16'hFFF0 constants;
  - the OV7670 default SLAVE_ADDR.
REQ-029 One sub-module, cfg_wait_timer (load/count/expire), is shared by PWRUP, DELAY and the watchdog, using the largest width of the three.

Verification
REQ-030 The bench uses a behavioural I2C master model with the same handshake, PWRUP_CYC=10, DELAY_CYC=20 and TIMEOUT_CYC=100.
REQ-031 Scenarios (stimulus -> required response):
  1. ROM {1280,1204,FFFF}, ACK all -> two launches; tx_data 12/80 then 12/04; done=1, 0 errors.
  2. ROM {FFF0,1100,FFFF} -> no I2C_En for 20 cycles after decode; one transfer; done=1.
  3. Entry 0 NACKed twice, then ACK -> 3 I2C_En pulses with rom_addr=0; done=1.
  4. Entry 0 always NACKed -> exactly 3 launches, then error=1, busy=0.
  5. Model stalls after the first tx_done -> error=1, 100 cycles after entering XFER.
  6. reset during XFER, then start -> I2C_En=0 and busy=0 the next cycle; a restart runs from rom_addr=0.
